// File: rtl/countdown_sequencer.sv
// Seconds countdown controller: load/start/pause/resume/clear with a prescaled decrement enable.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the loaded start value instead of expiring.
module countdown_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int SEC_W    = 6
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SEC_W-1:0] sec_in,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [SEC_W-1:0] sec_out,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             expired
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             tick_d, done_d;
  logic             count_en;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [SEC_W-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      sec_q    <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      tick     <= tick_d;
      done     <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Only the highest-priority asserted command acts; the count advances
  // only in RUN cycles where no command took effect.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sec_d    = sec_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    count_en = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (clear) begin
      state_d = IDLE;
      sec_d   = '0;
      presc_d = '0;
    end else if (load) begin
      state_d = IDLE;
      sec_d   = sec_in;
      presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = sec_in;
`endif
    end else if (start) begin
      case (state_q)
        IDLE: if (sec_q != '0) begin
          state_d = RUN;
          presc_d = '0;
        end
        PAUSE:   state_d = RUN;
        RUN:     count_en = 1'b1;
        default: ;
      endcase
    end else if (pause && state_q == RUN) begin
      state_d = PAUSE;
    end else if (state_q == RUN) begin
      count_en = 1'b1;
    end

    if (count_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (sec_q != '0) begin
          tick_d = 1'b1;
          if (sec_q == SEC_W'(1)) begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              sec_d = reload_q;
            end else begin
              sec_d   = '0;
              state_d = EXPIRED;
            end
`else
            sec_d   = '0;
            state_d = EXPIRED;
`endif
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign sec_out = sec_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Cycle-table bench for countdown_sequencer (TICK_DIV=4); expectations queued as a scoreboard.
module tb_countdown_sequencer;
  localparam int TD = 4;
  localparam int SW = 6;

  logic          clock_in = 1'b0;
  logic          reset_n  = 1'b0;
  logic          load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [SW-1:0] sec_in = '0;
  logic [SW-1:0] sec_out;
  logic          tick, running, done, expired;

  countdown_sequencer #(.TICK_DIV(TD), .SEC_W(SW)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .load(load), .sec_in(sec_in),
    .start(start), .pause(pause), .clear(clear), .sec_out(sec_out),
    .tick(tick), .running(running), .done(done), .expired(expired)
  );

  always #5 clock_in = ~clock_in;

  typedef struct packed {
    logic [SW-1:0] sec;
    logic          tk;
    logic          run;
    logic          dn;
    logic          exp;
  } out_t;

  typedef struct {
    logic          ld;
    logic [SW-1:0] si;
    logic          st;
    logic          pa;
    logic          cl;
    out_t          e;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vidx   = 0;

  function automatic out_t o(int s, bit t, bit r, bit d, bit e);
    o = {SW'(s), t, r, d, e};
  endfunction

  task automatic add(bit ld, int si, bit st, bit pa, bit cl, out_t e);
    vec_t v;
    v.ld = ld; v.si = SW'(si); v.st = st; v.pa = pa; v.cl = cl; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic idle(out_t e);
    add(0, 0, 0, 0, 0, e);
  endtask

  task automatic compare(string nm);
    out_t a, x;
    a = {sec_out, tick, running, done, expired};
    x = sb.pop_front();
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got sec=%0d tick=%b run=%b done=%b exp=%b, want sec=%0d tick=%b run=%b done=%b exp=%b",
               nm, a.sec, a.tk, a.run, a.dn, a.exp, x.sec, x.tk, x.run, x.dn, x.exp);
    end
  endtask

  task automatic run_vecs();
    while (vecs.size() > 0) begin
      vec_t v;
      v = vecs.pop_front();
      @(negedge clock_in);
      load = v.ld; sec_in = v.si; start = v.st; pause = v.pa; clear = v.cl;
      sb.push_back(v.e);
      @(posedge clock_in);
      #1;
      compare($sformatf("vec%0d", vidx));
      vidx++;
    end
    @(negedge clock_in);
    load = 0; start = 0; pause = 0; clear = 0; sec_in = '0;
  endtask

  initial begin
    // reset state
    #12;
    sb.push_back(o(0, 0, 0, 0, 0));
    compare("reset");
    @(negedge clock_in);
    reset_n = 1'b1;

    // basic countdown 3->2->1->0, ticks 4/8/12 edges after start
    add(1, 3, 0, 0, 0, o(3, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(3, 0, 1, 0, 0));
    repeat (3) idle(o(3, 0, 1, 0, 0));
    idle(o(2, 1, 1, 0, 0));
    repeat (3) idle(o(2, 0, 1, 0, 0));
    idle(o(1, 1, 1, 0, 0));
    repeat (3) idle(o(1, 0, 1, 0, 0));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    idle(o(3, 1, 1, 1, 0));
    idle(o(3, 0, 1, 0, 0));
    add(0, 0, 1, 0, 0, o(3, 0, 1, 0, 0));
    add(0, 0, 0, 1, 0, o(3, 0, 0, 0, 0));
`else
    idle(o(0, 1, 0, 1, 1));
    idle(o(0, 0, 0, 0, 1));
    add(0, 0, 1, 0, 0, o(0, 0, 0, 0, 1));
    add(0, 0, 0, 1, 0, o(0, 0, 0, 0, 1));
`endif

    // clear+load+start collision during RUN: clear wins
    add(1, 5, 0, 0, 0, o(5, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(5, 0, 1, 0, 0));
    idle(o(5, 0, 1, 0, 0));
    add(1, 9, 1, 0, 1, o(0, 0, 0, 0, 0));
    idle(o(0, 0, 0, 0, 0));

    // clear on the wrap cycle with sec=1: no tick, no done
    add(1, 1, 0, 0, 0, o(1, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(1, 0, 1, 0, 0));
    repeat (3) idle(o(1, 0, 1, 0, 0));
    add(0, 0, 0, 0, 1, o(0, 0, 0, 0, 0));

    // load on the wrap cycle: new value, no tick
    add(1, 2, 0, 0, 0, o(2, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(2, 0, 1, 0, 0));
    repeat (3) idle(o(2, 0, 1, 0, 0));
    add(1, 7, 0, 0, 0, o(7, 0, 0, 0, 0));

    // pause with prescaler at 2, hold 10 cycles, resume: tick 2 edges later
    add(1, 5, 0, 0, 0, o(5, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(5, 0, 1, 0, 0));
    repeat (2) idle(o(5, 0, 1, 0, 0));
    add(0, 0, 0, 1, 0, o(5, 0, 0, 0, 0));
    repeat (10) idle(o(5, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(5, 0, 1, 0, 0));
    idle(o(5, 0, 1, 0, 0));
    idle(o(4, 1, 1, 0, 0));

    // pause on the wrap cycle: no decrement; decrement on first RUN edge after resume
    repeat (3) idle(o(4, 0, 1, 0, 0));
    add(0, 0, 0, 1, 0, o(4, 0, 0, 0, 0));
    idle(o(4, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(4, 0, 1, 0, 0));
    idle(o(3, 1, 1, 0, 0));
    add(0, 0, 1, 0, 0, o(3, 0, 1, 0, 0));
    add(0, 0, 0, 0, 1, o(0, 0, 0, 0, 0));

    // zero guard, and load outranks start
    add(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(0, 0, 0, 0, 0));
    idle(o(0, 0, 0, 0, 0));
    add(0, 0, 0, 1, 0, o(0, 0, 0, 0, 0));
    add(1, 6, 1, 0, 0, o(6, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(6, 0, 1, 0, 0));
    idle(o(6, 0, 1, 0, 0));
    run_vecs();

    // async reset mid-RUN, between edges
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back(o(0, 0, 0, 0, 0));
    compare("async_reset_now");
    @(posedge clock_in);
    #1;
    sb.push_back(o(0, 0, 0, 0, 0));
    compare("async_reset_held");
    @(negedge clock_in);
    reset_n = 1'b1;
    add(0, 0, 1, 0, 0, o(0, 0, 0, 0, 0));
    idle(o(0, 0, 0, 0, 0));
    run_vecs();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    begin
      int cur;
      cur = 2;
      add(1, 2, 0, 0, 0, o(2, 0, 0, 0, 0));
      add(0, 0, 1, 0, 0, o(2, 0, 1, 0, 0));
      for (int k = 1; k <= 20; k++) begin
        bit t, d;
        t = (k % TD == 0);
        d = 0;
        if (t) begin
          if (cur == 1) begin cur = 2; d = 1; end
          else cur = cur - 1;
        end
        idle(o(cur, t, 1, d, 0));
      end
      run_vecs();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
